// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch front-end bus bundle: imem request/response, decode handshake, redirect
//
// Signals:
//   imem_req_valid/ready/addr  request channel to instruction memory
//   imem_rsp_valid/data        in-order response channel (no backpressure)
//   if_valid/id_ready          head-entry handshake to decode
//   if_instr/if_pc/if_pc_plus4/if_illegal  head-entry payload
//   redirect_valid/redirect_pc branch/jump redirect from execute
// Modports: master = fetch_queue side, slave = memory/decode/execute side.
interface fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output if_valid, if_instr, if_pc, if_pc_plus4, if_illegal,
        input  id_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_instr, if_pc, if_pc_plus4, if_illegal,
        output id_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with DEPTH-entry in-order response queue
//
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-high reset
//   bus    fetch_queue_if.master (imem request/response, decode handshake, redirect)
// Parameters: DEPTH (power of two, >= 2), RESET_PC.
// Optional feature macro: FETCH_PREDECODE_EN (per-entry illegal-opcode predecode bit).
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [CW:0]   in_use;
    logic          req_fire;
    logic          rsp;
    logic          enq;
    logic          deq;
    logic          redirect;

    assign redirect = bus.redirect_valid;
    assign rsp      = bus.imem_rsp_valid;

    // Credit rule: a request is only issued if its response is guaranteed a slot.
    assign in_use             = {1'b0, count} + {1'b0, outstanding};
    assign bus.imem_req_valid = !reset && !redirect && (in_use < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign enq      = rsp && !redirect && (discard == '0);
    assign deq      = bus.if_valid && bus.id_ready && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp);
            if (redirect) begin
                fetch_pc <= bus.redirect_pc;
                rsp_pc   <= bus.redirect_pc;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                // Every in-flight response is now stale. Responses already
                // marked for discard are themselves part of outstanding, so
                // the new discard is just what remains in flight after this
                // cycle's response; this keeps back-to-back redirects exact.
                if (outstanding == '0)
                    discard <= '0;
                else
                    discard <= outstanding - CW'(rsp);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp && (discard != '0))
                    discard <= discard - CW'(1);
                if (enq) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    tail   <= tail + AW'(1);
                end
                if (deq)
                    head <= head + AW'(1);
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end

    // Payload storage needs no reset: count gates visibility.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail]    <= rsp_pc;
            instr_mem[tail] <= bus.imem_rsp_data;
        end
    end

    assign bus.if_valid    = (count != '0);
    assign bus.if_pc       = pc_mem[head];
    assign bus.if_instr    = instr_mem[head];
    assign bus.if_pc_plus4 = pc_mem[head] + 32'd4;

`ifdef FETCH_PREDECODE_EN
    logic ill_mem [DEPTH];
    logic rsp_ill;

    always_comb begin
        rsp_ill = 1'b1;
        case (bus.imem_rsp_data[6:0])
            7'b0000011, 7'b0100011, 7'b0110011,
            7'b1100011, 7'b0010011, 7'b1101111: rsp_ill = 1'b0;
            default:                            rsp_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq)
            ill_mem[tail] <= rsp_ill;
    end

    assign bus.if_illegal = bus.if_valid && ill_mem[head];
`else
    assign bus.if_illegal = 1'b0;
`endif

    // A response with nothing in flight means the memory broke the protocol.
    assert property (@(posedge clk) disable iff (reset) !(rsp && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against an epoch-based model
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        memq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    int          tb_count = 0;
    int          fires    = 0;
    int          deqs     = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          p_ready  = 100;
    int          p_idr    = 100;
    int          p_redir  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2] ^ a[7:5])
            3'd0: op = 7'b0010011;
            3'd1: op = 7'b0000011;
            3'd2: op = 7'b0100011;
            3'd3: op = 7'b1111111;
            3'd4: op = 7'b0110011;
            3'd5: op = 7'b1100011;
            3'd6: op = 7'b1101111;
            default: op = 7'b0001111;
        endcase
        return {a[31:7] ^ 25'h1A5_A5A5, op};
    endfunction

    function automatic logic exp_ill(input logic [31:0] w);
`ifdef FETCH_PREDECODE_EN
        return !(w[6:0] inside {7'b0000011, 7'b0100011, 7'b0110011,
                                7'b1100011, 7'b0010011, 7'b1101111});
`else
        return 1'b0 && w[0];
`endif
    endfunction

    task automatic model_reset();
        memq.delete();
        tb_count = 0;
        epoch    = 0;
        exp_pc   = RESET_PC;
        exp_req  = RESET_PC;
    endtask

    // Called at a falling edge: drive inputs, compare, advance the model for
    // the coming rising edge, then wait for the next falling edge.
    task automatic step(input bit force_r, input logic [31:0] force_pc);
        logic        exp_rv;
        req_t        h;
        bus.imem_req_ready = ($urandom_range(99) < p_ready);
        bus.id_ready       = ($urandom_range(99) < p_idr);
        bus.redirect_valid = force_r || ($urandom_range(99) < p_redir);
        bus.redirect_pc    = force_r ? force_pc : ($urandom() & 32'hFFFF_FFFC);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom();
        end
        #1;
        check_eq("if_valid", 32'(bus.if_valid), 32'(tb_count != 0));
        if (!bus.if_valid)
            check_eq("if_illegal_idle", 32'(bus.if_illegal), 32'd0);
        exp_rv = !bus.redirect_valid && (tb_count + memq.size() < DEPTH);
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (bus.imem_req_valid)
            check_eq("req_addr", bus.imem_req_addr, exp_req);

        if (bus.imem_rsp_valid) begin
            h = memq.pop_front();
            if (!bus.redirect_valid && h.epoch == epoch)
                tb_count++;
        end
        if (bus.redirect_valid) begin
            epoch++;
            tb_count = 0;
            exp_pc   = bus.redirect_pc;
            exp_req  = bus.redirect_pc;
        end else begin
            if (bus.if_valid && bus.id_ready) begin
                check_eq("if_pc", bus.if_pc, exp_pc);
                check_eq("if_instr", bus.if_instr, mem_word(exp_pc));
                check_eq("if_pc_plus4", bus.if_pc_plus4, exp_pc + 32'd4);
                check_eq("if_illegal", 32'(bus.if_illegal), 32'(exp_ill(mem_word(exp_pc))));
                exp_pc = exp_pc + 32'd4;
                tb_count--;
                deqs++;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                h.addr  = bus.imem_req_addr;
                h.epoch = epoch;
                h.due   = cyc + $urandom_range(lat_max, lat_min);
                memq.push_back(h);
                exp_req = exp_req + 32'd4;
                fires++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 32'h0);
    endtask

    task automatic apply_reset();
        reset              = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.id_ready       = 1'b0;
        model_reset();
        #1;
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check_eq("rst_if_illegal", 32'(bus.if_illegal), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.imem_rsp_data = '0;
        bus.redirect_pc   = '0;
        @(negedge clk);
        apply_reset();

        // 1-cycle memory, decode always ready: sequential stream from RESET_PC.
        run(20);
        // Redirect coinciding with a response and a dequeue.
        step(1'b1, 32'h0000_0100);
        run(12);

        // Decode stalled after a fresh reset: exactly DEPTH requests fill the queue.
        @(negedge clk);
        apply_reset();
        p_idr = 0;
        fires = 0;
        run(12);
        check_eq("stall_fires", 32'(fires), 32'(DEPTH));
        p_idr = 100;
        run(12);

        // 3-cycle memory with requests in flight, then redirect to 0x100.
        lat_min = 3; lat_max = 3;
        run(7);
        step(1'b1, 32'h0000_0100);
        run(15);

        // Memory not ready for 5 cycles: address must hold.
        p_ready = 0;
        run(5);
        p_ready = 100;
        run(10);

        // PC wrap past 2^32.
        lat_min = 1; lat_max = 2;
        step(1'b1, 32'hFFFF_FFF8);
        run(12);

        // Randomized mix including back-to-back redirects.
        lat_min = 1; lat_max = 4;
        p_ready = 70; p_idr = 60; p_redir = 6;
        run(3000);

        // Reset mid-operation, then a short clean run.
        apply_reset();
        p_redir = 0; p_ready = 100; p_idr = 100;
        run(20);

        check_eq("deq_progress", 32'(deqs > 200), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
